t64_cag_rgb_pack: RTL and testbench

Downstream accumulate/round/pack stage of the CAG444→RGB888 custom-instruction datapath. Consumes the stream of signed 18-bit coefficient products from the 8s×10u multipliers. Per pixel it sums three products for each of R, G and B, rounds, scales by the coefficient fraction width, and saturates each channel to 8 bits. It packs two RGB888 pixels per 64-bit result word for the CVXIF writeback path.

---
 rtl/t64_cag_rgb_pack.sv | 108 ++++++++++
 tb/tb_t64_cag_rgb_pack.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t64_cag_rgb_pack.sv
// Accumulate/round/pack stage for the CAG444->RGB888 datapath.
// Per pixel: 9 product beats (R t0..t2, G t0..t2, B t0..t2) are summed per
// channel, rounded, shifted by FRAC, clamped to a byte, and two pixels are
// packed into one 64-bit result word held in a single-entry output register.
module t64_cag_rgb_pack #(
  parameter int FRAC = 8,
  parameter int PW   = 18
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [PW-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [63:0]          m_data,
  output logic [1:0]           m_npix,
  output logic                 m_last
);

  // Rounding constant: half an LSB of the scaled result.
  localparam logic [PW+3:0] RND = {{(PW+3){1'b0}}, 1'b1} << (FRAC - 1);

  logic [1:0]          term;
  logic [1:0]          chan;
  logic                pix;
  logic signed [PW+2:0] acc;
  logic [47:0]         pack_q;

  logic                last_beat;
  logic                emit_cand;
  logic                accept;
  logic                emit;
  logic signed [PW+3:0] sum;
  logic signed [PW+3:0] v;
  logic [7:0]          byte_val;
  logic [2:0]          slot;
  logic [47:0]         pack_next;

  // Handshake: only the emitting B t2 beat can stall, and only while the
  // output register is holding an unaccepted word.
  always_comb begin
    last_beat = (term == 2'd2) && (chan == 2'd2);
    emit_cand = last_beat && (pix || s_last);
    s_ready   = !ap_rst && !(emit_cand && m_valid && !m_ready);
    accept    = s_valid && s_ready;
    emit      = accept && emit_cand;
  end

  // Channel finish: round, arithmetic shift, clamp, and place the byte.
  always_comb begin
    sum       = {acc[PW+2], acc} + {{4{s_data[PW-1]}}, s_data} + RND;
    v         = sum >>> FRAC;
    if (v[PW+3])
      byte_val = 8'h00;
    else if (|v[PW+2:8])
      byte_val = 8'hFF;
    else
      byte_val = v[7:0];
    slot      = (pix ? 3'd3 : 3'd0) + {1'b0, chan};
    pack_next = pack_q;
    pack_next[{slot, 3'b000} +: 8] = byte_val;
  end

  // Beat counters, accumulator and pack buffer.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      term   <= 2'd0;
      chan   <= 2'd0;
      pix    <= 1'b0;
      acc    <= '0;
      pack_q <= '0;
    end else if (accept) begin
      if (term == 2'd2) begin
        term <= 2'd0;
        chan <= (chan == 2'd2) ? 2'd0 : chan + 2'd1;
        pack_q <= emit ? 48'd0 : pack_next;
      end else begin
        term <= term + 2'd1;
      end
      if (term == 2'd0)
        acc <= {{3{s_data[PW-1]}}, s_data};
      else
        acc <= acc + {{3{s_data[PW-1]}}, s_data};
      if (last_beat)
        pix <= emit ? 1'b0 : 1'b1;
    end
  end

  // Single-entry output register; a new emit overwrites a word being taken.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_valid <= 1'b0;
      m_data  <= 64'd0;
      m_npix  <= 2'd0;
      m_last  <= 1'b0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_data  <= {16'h0000, pack_next};
      m_npix  <= {1'b0, pix} + 2'd1;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t64_cag_rgb_pack.sv
// Bench for t64_cag_rgb_pack: vector table, hand sequences for stall and
// reset, then randomized traffic checked against an integer reference model.
module tb_t64_cag_rgb_pack;

  localparam int FRAC = 8;
  localparam int PW   = 18;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [PW-1:0] s_data = '0;
  logic                 s_last = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [63:0]          m_data;
  logic [1:0]           m_npix;
  logic                 m_last;

  always #5 ap_clk = ~ap_clk;

  t64_cag_rgb_pack #(.FRAC(FRAC), .PW(PW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_npix (m_npix),
    .m_last (m_last)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: products of the pixel in flight, bytes of the
  // word being built, and the word sitting in the output register.
  int          beat_i;
  int          pix_n;
  int          prods[9];
  logic [7:0]  pack_b[6];
  bit          out_full;
  logic [63:0] out_word;
  logic [1:0]  out_npix;
  bit          out_last;

  bit rst_drive = 1'b1;
  bit rst_prev  = 1'b0;
  int rdy_mode  = 0;
  bit gap_mode  = 1'b0;
  bit last_srdy;

  typedef struct packed {
    logic [8:0][17:0] p;
    logic [3:0]       lb;
    logic             emit;
    logic [47:0]      word;
    logic [1:0]       npix;
    logic             last;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_byte(input int a, input int b, input int c);
    int s;
    int q;
    s = a + b + c + (1 << (FRAC - 1));
    q = s >>> FRAC;
    if (q < 0) return 8'h00;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  function automatic logic [63:0] pack_word();
    return {16'h0000, pack_b[5], pack_b[4], pack_b[3], pack_b[2], pack_b[1], pack_b[0]};
  endfunction

  task automatic model_reset();
    beat_i   = 0;
    pix_n    = 0;
    for (int i = 0; i < 6; i++) pack_b[i] = 8'h00;
    out_full = 1'b0;
    out_word = 64'd0;
    out_npix = 2'd0;
    out_last = 1'b0;
  endtask

  function automatic bit pick_rdy();
    if (rdy_mode == 1) return ($urandom_range(0, 3) != 0);
    if (rdy_mode == 2) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive at the falling edge, check just after, step the model
  // at the rising edge.
  task automatic cycle(input bit v, input int d, input bit l, input bit r, output bit acc);
    bit exp_rdy;
    @(negedge ap_clk);
    ap_rst  = rst_drive;
    s_valid = v;
    s_data  = d[PW-1:0];
    s_last  = l;
    m_ready = r;
    #1;
    acc = 1'b0;
    if (rst_drive) begin
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      if (rst_prev) begin
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_npix", 64'(m_npix), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
      end
      @(posedge ap_clk);
      model_reset();
      rst_prev = 1'b1;
      return;
    end
    rst_prev  = 1'b0;
    exp_rdy   = !(beat_i == 8 && (pix_n == 1 || l) && out_full && !r);
    last_srdy = s_ready;
    chk("s_ready", 64'(s_ready), 64'(exp_rdy));
    chk("m_valid", 64'(m_valid), 64'(out_full));
    if (out_full) begin
      chk("m_data", m_data, out_word);
      chk("m_npix", 64'(m_npix), 64'(out_npix));
      chk("m_last", 64'(m_last), 64'(out_last));
    end
    acc = v && exp_rdy;
    @(posedge ap_clk);
    if (out_full && r) out_full = 1'b0;
    if (acc) begin
      prods[beat_i] = d;
      if (beat_i % 3 == 2)
        pack_b[pix_n * 3 + beat_i / 3] = chan_byte(prods[beat_i-2], prods[beat_i-1], prods[beat_i]);
      if (beat_i == 8) begin
        if (pix_n == 1 || l) begin
          out_word = pack_word();
          out_npix = 2'(pix_n + 1);
          out_last = l;
          out_full = 1'b1;
          for (int i = 0; i < 6; i++) pack_b[i] = 8'h00;
          pix_n = 0;
        end else begin
          pix_n = 1;
        end
        beat_i = 0;
      end else begin
        beat_i++;
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1, acc);
  endtask

  task automatic send_beat(input int d, input bit l);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    if (gap_mode && $urandom_range(0, 3) == 0) cycle(1'b0, 0, 1'b0, pick_rdy(), acc);
    acc = 1'b0;
    while (!acc && n < 40) begin
      cycle(1'b1, d, l, pick_rdy(), acc);
      n++;
    end
    if (!acc) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_simple(input int r0, input int g0, input int b0, input bit l);
    send_beat(r0, 1'b0); send_beat(0, 1'b0); send_beat(0, 1'b0);
    send_beat(g0, 1'b0); send_beat(0, 1'b0); send_beat(0, 1'b0);
    send_beat(b0, 1'b0); send_beat(0, 1'b0); send_beat(0, l);
  endtask

  function automatic vec_t mk(input int r0, input int r1, input int r2,
                              input int g0, input int g1, input int g2,
                              input int b0, input int b1, input int b2,
                              input int lb, input bit emit, input logic [47:0] word,
                              input logic [1:0] npix, input bit last);
    vec_t t;
    t.p[0] = r0[17:0]; t.p[1] = r1[17:0]; t.p[2] = r2[17:0];
    t.p[3] = g0[17:0]; t.p[4] = g1[17:0]; t.p[5] = g2[17:0];
    t.p[6] = b0[17:0]; t.p[7] = b1[17:0]; t.p[8] = b2[17:0];
    t.lb   = 4'(lb);
    t.emit = emit;
    t.word = word;
    t.npix = npix;
    t.last = last;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit acc;
    model_reset();

    // lb: 8 = s_last on B t2, 4 = stray s_last on G t1, 15 = none.
    // Bytes: R=(25600+128)>>8=100, G=(13056+128)>>8=51.
    tv[0] = mk(25600, 0, 0, 12800, 256, 0, 0, 0, 0, 15, 1'b0, 48'h0, 2'd0, 1'b0);
    tv[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 1'b1, 48'h000000_003364, 2'd2, 1'b0);
    // R=1, G=0, B=-2 clamps to 0; stray s_last must not flush.
    tv[2] = mk(128, 0, 0, 127, 0, 0, -512, 0, 0, 4, 1'b0, 48'h0, 2'd0, 1'b0);
    // R saturates high, G saturates low, B=(2500+128)>>8=10.
    tv[3] = mk(131071, 131071, 131071, -131072, -131072, -131072, 1000, 2000, -500,
               15, 1'b1, 48'h0A00FF_000001, 2'd2, 1'b0);
    // Odd flush: R=255 exactly, G=0, B=-1 -> 0.
    tv[4] = mk(65280, 0, 0, -128, 0, 0, -129, 0, 0, 8, 1'b1, 48'h000000_0000FF, 2'd1, 1'b1);
    // R=256 -> FF, G=255, B=1.
    tv[5] = mk(65408, 0, 0, 65407, 0, 0, 100, 100, 100, 15, 1'b0, 48'h0, 2'd0, 1'b0);
    // R=0, G=2, B=2 and the pair ends the request.
    tv[6] = mk(-1, -1, -1, 200, 200, 200, 0, 0, 384, 8, 1'b1, 48'h020200_01FFFF, 2'd2, 1'b1);

    rst_drive = 1'b1;
    idle(3);
    rst_drive = 1'b0;
    idle(1);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 9; k++)
        send_beat(int'($signed(tv[i].p[k])), k == int'(tv[i].lb));
      #2;
      chk("tbl_m_valid", 64'(m_valid), 64'(tv[i].emit));
      if (tv[i].emit) begin
        chk("tbl_m_data", m_data, {16'h0000, tv[i].word});
        chk("tbl_m_npix", 64'(m_npix), 64'(tv[i].npix));
        chk("tbl_m_last", 64'(m_last), 64'(tv[i].last));
      end
    end
    idle(2);

    // Backpressure: word A (R0=3) held while word B (R1=7) completes.
    rdy_mode = 2;
    send_simple(768, 0, 0, 1'b0);
    send_simple(0, 0, 0, 1'b0);
    send_simple(0, 0, 0, 1'b0);
    send_beat(1792, 1'b0);
    for (int k = 1; k < 8; k++) send_beat(0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, 0, 1'b0, 1'b0, acc);
      chk("bp_stall_ready", 64'(last_srdy), 64'd0);
      chk("bp_hold_data", m_data, 64'h0000_0000_0000_0003);
    end
    cycle(1'b1, 0, 1'b0, 1'b1, acc);
    chk("bp_release_ready", 64'(last_srdy), 64'd1);
    #2;
    chk("bp_word2_valid", 64'(m_valid), 64'd1);
    chk("bp_word2_data", m_data, 64'h0000_0000_0700_0000);
    cycle(1'b0, 0, 1'b0, 1'b0, acc);
    cycle(1'b0, 0, 1'b0, 1'b1, acc);
    rdy_mode = 0;

    // Reset with an unaccepted word pending and a half-fed pixel.
    rdy_mode = 2;
    send_simple(256, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) send_beat(1000, 1'b0);
    rdy_mode = 0;
    rst_drive = 1'b1;
    idle(2);
    rst_drive = 1'b0;
    send_simple(512, 0, 2304, 1'b1);
    #2;
    chk("rst_fresh_valid", 64'(m_valid), 64'd1);
    chk("rst_fresh_data", m_data, 64'h0000_0000_0009_0002);
    chk("rst_fresh_npix", 64'(m_npix), 64'd1);
    chk("rst_fresh_last", 64'(m_last), 64'd1);
    idle(2);

    // Randomized traffic with gaps, random m_ready and random s_last.
    rdy_mode = 1;
    gap_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      for (int k = 0; k < 9; k++) begin
        int d;
        bit l;
        d = int'($urandom_range(0, 262143)) - 131072;
        if (k == 8) l = ($urandom_range(0, 2) == 0);
        else        l = ($urandom_range(0, 7) == 0);
        send_beat(d, l);
      end
    end
    rdy_mode = 0;
    gap_mode = 1'b0;
    idle(3);
    chk("end_empty", 64'(m_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
